// File: rtl/acc_imem_loader.sv
// rtl/acc_imem_loader.sv - boot-time byte-stream to instruction-memory word loader
//
// Packs an incoming byte stream little-endian into DATA_W-bit words and writes
// them to sequential imem addresses starting at 0. The CPU is released
// (cpu_run) once the word carrying the final byte has been written. A program
// that would not fit in 2**ADDR_W words ends in a sticky overflow error.
//
// Ports:
//   clk, rst_n     clock (posedge) and synchronous active-low reset
//   in_valid       byte stream valid
//   in_ready       loader can accept a byte (IDLE/LOAD)
//   in_data        byte payload
//   in_last        marks final byte of the program
//   imem_we        one-cycle write strobe per word
//   imem_waddr     write address (valid with imem_we)
//   imem_wdata     write data (valid with imem_we)
//   cpu_run        program loaded, CPU may execute
//   load_count     words written so far
//   err_overflow   program exceeded imem capacity
module acc_imem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   load_count,
    output logic              err_overflow
);

    localparam int BPW   = DATA_W / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic              accept;
    logic [DATA_W-1:0] merged;

    assign in_ready     = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept       = in_valid && in_ready;
    assign merged       = asm_q | (DATA_W'(in_data) << {idx_q, 3'b000});
    assign imem_we      = we_q;
    assign imem_waddr   = cnt_q[ADDR_W-1:0];
    assign imem_wdata   = wdata_q;
    assign cpu_run      = (state_q == S_DONE);
    assign load_count   = cnt_q;
    assign err_overflow = (state_q == S_ERR);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (accept) begin
            if (state_q == S_IDLE) begin
                state_d = S_LOAD;
            end
            if ((idx_q == IDX_W'(BPW - 1)) || in_last) begin
                // Assembly register is cleared per word, so a short final word
                // leaves its unfilled upper bytes at zero.
                wdata_d = merged;
                we_d    = 1'b1;
                last_d  = in_last;
                idx_d   = '0;
                asm_d   = '0;
            end else begin
                asm_d = merged;
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (we_q) begin
            cnt_d = cnt_q + (ADDR_W + 1)'(1);
            if (last_q) begin
                state_d = S_DONE;
            end else if (cnt_q[ADDR_W-1:0] == '1) begin
                state_d = S_ERR;
            end
            // A byte accepted alongside the terminating write must not
            // produce another write after the load has ended.
            if (last_q || (cnt_q[ADDR_W-1:0] == '1)) begin
                we_d  = 1'b0;
                idx_d = '0;
                asm_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
